// File: rtl/bitwise_unit_arbiter.sv
`default_nettype none
// ============================================================================
// bitwise_unit_arbiter : round-robin share of one 64-bit AND/OR/XOR/XNOR unit
// Revision 1.0
// ============================================================================
module bitwise_unit_arbiter #(
  parameter int N_REQ         = 2,
  parameter int SETTLE_CYCLES = 1,
  localparam int ID_W         = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [2*N_REQ-1:0]    req_op,
  input  logic [64*N_REQ-1:0]   req_a,
  input  logic [64*N_REQ-1:0]   req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [63:0]           resp_data,
  output logic                  busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [63:0]        a_q, a_d;
  logic [63:0]        b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               resp_valid_q, resp_valid_d;
  logic [63:0]        resp_data_q, resp_data_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    grant_next;
  logic [63:0]        and_w, or_w, xor_w, xnor_w;
  logic [63:0]        result_w;

  // Walk downward so the requester closest to rr_ptr wins.
  always_comb begin
    logic [ID_W:0] idx_wide;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_wide    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx_wide = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx_wide >= (ID_W+1)'(N_REQ)) begin
        idx_wide = idx_wide - (ID_W+1)'(N_REQ);
      end
      if (req_valid[idx_wide[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx_wide[ID_W-1:0];
      end
    end
  end

  always_comb begin
    logic [ID_W:0] nxt_wide;
    nxt_wide = {1'b0, grant_idx} + (ID_W+1)'(1);
    if (nxt_wide == (ID_W+1)'(N_REQ)) begin
      nxt_wide = '0;
    end
    grant_next = nxt_wide[ID_W-1:0];
  end

  generate
    for (genvar i = 0; i < 64; i++) begin : g_bit
      assign and_w[i]  = a_q[i] & b_q[i];
      assign or_w[i]   = a_q[i] | b_q[i];
      assign xor_w[i]  = a_q[i] ^ b_q[i];
      assign xnor_w[i] = ~(a_q[i] ^ b_q[i]);
    end
  endgenerate

  always_comb begin
    case (op_q)
      2'b00:   result_w = and_w;
      2'b01:   result_w = or_w;
      2'b10:   result_w = xor_w;
      default: result_w = xnor_w;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    req_ready    = '0;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          a_d      = req_a[64*grant_idx +: 64];
          b_d      = req_b[64*grant_idx +: 64];
          op_d     = req_op[2*grant_idx +: 2];
          id_d     = grant_idx;
          rr_ptr_d = grant_next;
          cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          resp_data_d  = result_w;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = id_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire
